// File: rtl/sr_latch_bank.sv
// Clocked, gated bank of WIDTH SR cells with forbidden-input resolution, change pulses,
// and sticky/counted illegal detection. Optional two-edge input filter: SR_LATCH_BANK_FILTER_EN.
module sr_lane #(
  parameter int   ILLEGAL_MODE = 0,
  parameter logic RST_BIT      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic s_n,
  input  logic r_n,
  output logic q,
  output logic changed,
  output logic forb
);
  typedef enum logic {HELD0 = 1'b0, HELD1 = 1'b1} state_t;

  state_t state_q, state_d;
  logic   changed_q, changed_d;
  logic   act_s_n, act_r_n;

  // Detection uses the raw inputs so that filtering never delays illegal reporting.
  assign forb = en & ~s_n & ~r_n;

`ifdef SR_LATCH_BANK_FILTER_EN
  logic       arm_q, arm_d;
  logic [1:0] pair_q, pair_d;

  always_comb begin
    arm_d   = 1'b0;
    pair_d  = pair_q;
    act_s_n = 1'b1;
    act_r_n = 1'b1;
    if (en && ({s_n, r_n} != 2'b11)) begin
      if (arm_q && (pair_q == {s_n, r_n})) begin
        act_s_n = s_n;
        act_r_n = r_n;
      end else begin
        arm_d  = 1'b1;
        pair_d = {s_n, r_n};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_q  <= 1'b0;
      pair_q <= 2'b11;
    end else begin
      arm_q  <= arm_d;
      pair_q <= pair_d;
    end
  end
`else
  assign act_s_n = s_n | ~en;
  assign act_r_n = r_n | ~en;
`endif

  always_comb begin
    state_d = state_q;
    case ({act_s_n, act_r_n})
      2'b01: state_d = HELD1;
      2'b10: state_d = HELD0;
      2'b00: begin
        case (ILLEGAL_MODE)
          1:       state_d = HELD1;
          2:       state_d = HELD0;
          3:       state_d = (state_q == HELD1) ? HELD0 : HELD1;
          default: state_d = state_q;
        endcase
      end
      default: state_d = state_q;
    endcase
    changed_d = (state_d != state_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RST_BIT ? HELD1 : HELD0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      changed_q <= changed_d;
    end
  end

  assign q       = (state_q == HELD1);
  assign changed = changed_q;
endmodule

module sr_latch_bank #(
  parameter int               WIDTH        = 8,
  parameter int               ILLEGAL_MODE = 0,
  parameter int               CNT_W        = 8,
  parameter logic [WIDTH-1:0] RESET_VAL    = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             C,
  input  logic [WIDTH-1:0] S_n,
  input  logic [WIDTH-1:0] R_n,
  input  logic             clr_illegal,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic [WIDTH-1:0] changed,
  output logic [WIDTH-1:0] illegal_sticky,
  output logic [CNT_W-1:0] illegal_cnt
);
  logic [WIDTH-1:0] forb;
  logic [WIDTH-1:0] sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    sr_lane #(
      .ILLEGAL_MODE(ILLEGAL_MODE),
      .RST_BIT     (RESET_VAL[i])
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (C),
      .s_n    (S_n[i]),
      .r_n    (R_n[i]),
      .q      (Q[i]),
      .changed(changed[i]),
      .forb   (forb[i])
    );
  end

  // Clear wins over a same-edge forbidden event.
  always_comb begin
    sticky_d = sticky_q | forb;
    cnt_d    = cnt_q;
    if ((|forb) && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
    if (clr_illegal) begin
      sticky_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= '0;
      cnt_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign Qn             = ~Q;
  assign illegal_sticky = sticky_q;
  assign illegal_cnt    = cnt_q;
endmodule
